// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl_pkg: shared FSM encoding and default opcodes          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mem_access_ctrl_pkg;

  localparam int STATE_W = 1;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

  localparam logic [4:0] DEF_SW_OPC = 5'b00111;
  localparam logic [4:0] DEF_LW_OPC = 5'b01000;

  localparam int WAIT_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wait_timer: clearable saturating wait counter with timeout flag   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int          CNT_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Expiry fires on the wait cycle whose increment would reach TIMEOUT.
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = enable & (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_access_ctrl: memory-stage load/store handshake with timeout       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int                OPC_W   = 5,
  parameter int                ADDR_W  = 12,
  parameter int                DATA_W  = 32,
  parameter logic [OPC_W-1:0]  SW_OPC  = OPC_W'(DEF_SW_OPC),
  parameter logic [OPC_W-1:0]  LW_OPC  = OPC_W'(DEF_LW_OPC),
  parameter int unsigned       TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              err_timeout
);

  state_t r_state;
  state_t w_next_state;
  logic   w_is_st;
  logic   w_is_ld;
  logic   w_busy;
  logic   w_accept;
  logic   w_done;
  logic   w_expired;
  logic   r_is_st;
  logic   r_flushed;

  assign w_is_st  = (opcode_in == SW_OPC);
  assign w_is_ld  = (opcode_in == LW_OPC);
  assign w_busy   = (r_state == ST_BUSY);
  assign w_accept = valid_in & ~flush & (w_is_st | w_is_ld) & ~w_busy;
  assign w_done   = w_busy & dmem_ack;

  mem_wait_timer #(
    .CNT_W   (WAIT_CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_accept),
    .enable  (w_busy & ~dmem_ack),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
      ST_BUSY: if (dmem_ack || w_expired) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Stall is dropped on the ack cycle so the pipeline advances with the result.
  always_comb begin
    dmem_req  = w_busy;
    dmem_wren = w_busy & r_is_st;
    stall_out = rst_n & (w_accept | (w_busy & ~dmem_ack));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      err_timeout <= 1'b0;
      r_is_st     <= 1'b0;
      r_flushed   <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      err_timeout <= 1'b0;
      if (w_accept) begin
        dmem_addr  <= addr_in;
        dmem_wdata <= data_in;
        r_is_st    <= w_is_st;
        r_flushed  <= 1'b0;
      end else if (w_busy && flush) begin
        r_flushed <= 1'b1;
      end
      if (w_done && !r_is_st) begin
        rdata_out   <= dmem_rdata;
        rdata_valid <= ~(r_flushed | flush);
      end
      if (w_expired) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
